// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//   Turns debounced push-button levels into clean single-cycle event strobes
//   for the application FSMs: press, release, a one-shot long-press and
//   periodic auto-repeat while held. A shared prescaler provides the hold-time
//   tick. Each channel runs its own IDLE/PRESSED/HELD state machine.
//
// Ports
//   Clock     in   1      system clock, rising edge
//   Reset     in   1      asynchronous, active-low reset
//   iPushBtn  in   N_BTN  debounced levels, 1 = pressed, synchronous to Clock
//   oPress    out  N_BTN  1-cycle strobe on press
//   oRelease  out  N_BTN  1-cycle strobe on release
//   oLong     out  N_BTN  1-cycle strobe, once per press, at long-press time
//   oRepeat   out  N_BTN  1-cycle strobe every REPEAT_TICKS while held
//   oHeld     out  N_BTN  level, high while channel is in HELD
// -----------------------------------------------------------------------------
module button_event_gen #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [N_BTN-1:0] iPushBtn,
  output logic [N_BTN-1:0] oPress,
  output logic [N_BTN-1:0] oRelease,
  output logic [N_BTN-1:0] oLong,
  output logic [N_BTN-1:0] oRepeat,
  output logic [N_BTN-1:0] oHeld
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  // A divide-by-one prescaler still needs a one-bit register to stay legal.
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;

  logic [N_BTN-1:0] last_q,    last_d;
  logic [N_BTN-1:0] press_q,   press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q,    long_d;
  logic [N_BTN-1:0] repeat_q,  repeat_d;
  logic [N_BTN-1:0] held_q,    held_d;
  logic [N_BTN-1:0] rise, fall;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);

    last_d    = iPushBtn;
    rise      = iPushBtn & ~last_q;
    fall      = ~iPushBtn & last_q;

    press_d   = rise;
    release_d = fall;
    long_d    = '0;
    repeat_d  = '0;
    held_d    = '0;

    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      // Release has priority over a threshold tick in the same cycle, so a
      // late release never produces a stray long/repeat strobe.
      if (fall[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              state_d[i] = ST_PRESSED;
              cnt_d[i]   = '0;
            end
          end
          ST_PRESSED: begin
            if (tick) begin
              if (cnt_q[i] + CW'(1) == LONG_LAST) begin
                long_d[i]  = 1'b1;
                state_d[i] = ST_HELD;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i]   = cnt_q[i] + CW'(1);
              end
            end
          end
          ST_HELD: begin
            if (tick) begin
              if (cnt_q[i] + CW'(1) == REPEAT_LAST) begin
                repeat_d[i] = 1'b1;
                cnt_d[i]    = '0;
              end else begin
                cnt_d[i]    = cnt_q[i] + CW'(1);
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end

      // Registered from the next state so oHeld falls on the same edge that
      // raises oRelease.
      held_d[i] = (state_d[i] == ST_HELD);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q   <= '0;
      last_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      held_q    <= '0;
      // NOTE: the per-channel state and counter arrays are control registers,
      // not storage, so every element is reset explicitly.
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      last_q    <= last_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign oPress   = press_q;
  assign oRelease = release_q;
  assign oLong    = long_q;
  assign oRepeat  = repeat_q;
  assign oHeld    = held_q;

endmodule
